bcnt_ctrl: RTL and testbench
============================

# bcnt_ctrl

Multi-cycle bit-count unit for the execute stage. It time-multiplexes one narrow CHUNK-bit ones-counter across a 32-bit operand over 32/CHUNK cycles, then post-processes the count according to the requested operation. It uses a start/busy/done handshake, in the same way as the multiply/divide unit. Hazard logic stalls dependent instructions while the unit is busy.

## Interface
Parameters:
- CHUNK, default 8: bits counted per cycle. Legal values are 4, 8, 16 and 32. N = 32/CHUNK cycles per operation.

Ports:
- clk — input, 1 bit: the single clock. Logic is rising-edge triggered.
- reset — input, 1 bit: asynchronous, active-high reset. Clears all state immediately.
- start — input, 1 bit: issue request. Accepted only when the FSM is in IDLE.
- op — input, 2 bits: operation select. Sampled with start.
- src — input, 32 bits: operand. Sampled with start.
- busy — output, 1 bit: high while the FSM is in RUN.
- done — output, 1 bit: one-cycle pulse after result is updated.
- result — output, 32 bits: zero-extended count result. Held until the next completion.
- flush — input, 1 bit: abort request. The port exists only when BCNT_FLUSH_EN is defined.

## Operation
- FSM states are IDLE and RUN. Internal registers:
  - shreg, 32 bits
  - op_q, 2 bits
  - acc, 6 bits
  - cnt, log2(N)+1 bits
- IDLE with start=1: shreg<=src, op_q<=op, acc<=0, cnt<=0, then go to RUN.
- IDLE with start=0: hold state.
- Each RUN cycle:
  - acc <= acc + ones(shreg[CHUNK-1:0])
  - shreg <= shreg >> CHUNK
  - cnt <= cnt+1
- On the RUN edge where cnt==N-1:
  - result <= f(op_q, final acc)
  - done <= 1 for one cycle
  - state goes to IDLE.
- f by op_q:
  - 00 POP: acc.
  - 01 ZERO: 32-acc.
  - 10 PAR: {31'b0, acc[0]}.
  - 11 ALL1: {31'b0, acc==32}.
- Width rule: acc is 6 bits and its maximum is 32, so no overflow occurs. Results are zero-extended to 32 bits.
- start in RUN is ignored. It has no effect on any register, and no request is queued.
- Hazard logic must stall on (start | busy), because busy rises only one cycle after start.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, acc=0, cnt=0, shreg=0, op_q=0. Reset takes effect asynchronously, including in the middle of an operation. After reset the unit is idle with no done pulse.
- start is sampled at edge 0.
- busy is high from after edge 0 until edge N, i.e. for exactly N cycles.
- result is valid, and done is high, in the cycle after edge N. Latency from the start edge to valid result is N cycles.
- Back-to-back: start is accepted in the done cycle, because the state is IDLE. busy rises again in the next cycle, and result keeps the previous value until the new completion.
- done is registered; busy is decoded from the registered state. Neither output has a combinational path from inputs.
- CHUNK=32 gives N=1: busy is high for one cycle, and result appears one cycle after start.

## Configuration
- BCNT_FLUSH_EN defined:
  - The flush port exists. flush=1 at an edge forces state IDLE and clears acc and cnt.
  - No done pulse is generated, and result is unchanged.
  - If flush and start occur in the same cycle, flush wins and start is dropped.
  - Used for exception/eret pipeline flushes.
- BCNT_FLUSH_EN undefined: there is no flush port, and every accepted operation runs to completion.

## Structure
- Shared package bcnt_pkg holds:
  - the op encodings BCNT_POP=2'b00, BCNT_ZERO=2'b01, BCNT_PAR=2'b10, BCNT_ALL1=2'b11
  - the state encoding BCNT_IDLE, BCNT_RUN
  - the word width 32.
- Sub-module bcnt_chunk: a purely combinational CHUNK-bit ones-counter with output width log2(CHUNK)+1. It is instantiated once; the controller owns all sequencing.

## Test plan
- reset, then start, POP, src=32'hFFFFFFFF, CHUNK=8 -> busy high 4 cycles; done high in the 5th cycle after start; result=32.
- ZERO with src=32'h0000000F -> result=28. POP with src=0 -> result=0, and done still pulses after 4 cycles.
- PAR with src=32'h80000001 -> result=0. PAR with 32'h80000003 -> result=1. ALL1 with 32'hFFFFFFFF -> result=1.
- POP 32'h000000FF, then start with src=32'hFFFFFFFF in the 2nd busy cycle -> result=8, exactly one done pulse, busy drops on schedule.
- Back-to-back: POP 32'h1, then start POP 32'h3 in the done cycle -> result=1, then result=2 four cycles later, with busy high again immediately after the done cycle.
- Reset mid-RUN in cycle 2 -> busy=0, done=0 and result=0 immediately, with no later done. With BCNT_FLUSH_EN, flush mid-RUN -> no done, result keeps its prior value, and the next start works normally.

Source files
------------

// File: rtl/bcnt_pkg.sv
// Shared definitions for the multi-cycle bit-count unit: op and state encodings,
// word width and the result post-processing function.
package bcnt_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        BCNT_POP  = 2'b00,
        BCNT_ZERO = 2'b01,
        BCNT_PAR  = 2'b10,
        BCNT_ALL1 = 2'b11
    } bcnt_op_e;

    typedef enum logic {
        BCNT_IDLE = 1'b0,
        BCNT_RUN  = 1'b1
    } bcnt_state_e;

    // The final count never exceeds 32, so it fits in 6 bits and zero-extends cleanly.
    function automatic logic [WORD_W-1:0] bcnt_post(input bcnt_op_e op, input logic [5:0] acc);
        logic [WORD_W-1:0] acc_w;
        acc_w = {{(WORD_W-6){1'b0}}, acc};
        case (op)
            BCNT_POP:  return acc_w;
            BCNT_ZERO: return WORD_W'(WORD_W) - acc_w;
            BCNT_PAR:  return {{(WORD_W-1){1'b0}}, acc[0]};
            default:   return {{(WORD_W-1){1'b0}}, (acc == 6'd32)};
        endcase
    endfunction

endpackage

// File: rtl/bcnt_chunk.sv
// Combinational ones-counter over one CHUNK-bit slice of the operand.
module bcnt_chunk #(
    parameter int CHUNK = 8,
    parameter int OUT_W = $clog2(CHUNK) + 1
) (
    input  logic [CHUNK-1:0] bits,
    output logic [OUT_W-1:0] ones
);

    always_comb begin
        ones = '0;
        for (int i = 0; i < CHUNK; i++) begin
            ones = ones + OUT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/bcnt_ctrl.sv
// Bit-count controller: start/busy/done sequencing over WORD_W/CHUNK cycles.
// Optional abort port enabled by defining BCNT_FLUSH_EN.
module bcnt_ctrl
    import bcnt_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WORD_W-1:0] src,
`ifdef BCNT_FLUSH_EN
    input  logic              flush,
`endif
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] result
);

    localparam int N      = WORD_W / CHUNK;
    localparam int CNT_W  = $clog2(N) + 1;
    localparam int ONES_W = $clog2(CHUNK) + 1;

    bcnt_state_e       state, state_d;
    logic [WORD_W-1:0] shreg;
    bcnt_op_e          op_q;
    logic [5:0]        acc;
    logic [5:0]        acc_sum;
    logic [CNT_W-1:0]  cnt;
    logic [ONES_W-1:0] chunk_ones;
    logic              last;
    logic              kill;

`ifdef BCNT_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    bcnt_chunk #(.CHUNK(CHUNK)) u_chunk (
        .bits (shreg[CHUNK-1:0]),
        .ones (chunk_ones)
    );

    assign acc_sum = acc + 6'(chunk_ones);
    assign last    = (state == BCNT_RUN) && (cnt == CNT_W'(N - 1));
    assign busy    = (state == BCNT_RUN);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state;
        case (state)
            BCNT_IDLE: if (start) state_d = BCNT_RUN;
            BCNT_RUN:  if (last)  state_d = BCNT_IDLE;
            default:              state_d = BCNT_IDLE;
        endcase
        if (kill) state_d = BCNT_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BCNT_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg  <= '0;
            op_q   <= BCNT_POP;
            acc    <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                // An abort drops any start seen in the same cycle and leaves result untouched.
                acc <= '0;
                cnt <= '0;
            end else if (state == BCNT_IDLE) begin
                if (start) begin
                    shreg <= src;
                    op_q  <= bcnt_op_e'(op);
                    acc   <= '0;
                    cnt   <= '0;
                end
            end else begin
                acc   <= acc_sum;
                shreg <= shreg >> CHUNK;
                cnt   <= cnt + CNT_W'(1);
                if (last) begin
                    result <= bcnt_post(op_q, acc_sum);
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcnt_ctrl.sv
// Directed self-checking bench for bcnt_ctrl at CHUNK=8 (four cycles per operation).
module tb_bcnt_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src;
`ifdef BCNT_FLUSH_EN
    logic        flush = 1'b0;
`endif
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    bcnt_ctrl #(.CHUNK(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src    (src),
`ifdef BCNT_FLUSH_EN
        .flush  (flush),
`endif
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Issues one operation at a negedge and observes ten following negedges.
    // Sample i is the cycle after edge i-1 (edge 0 is the start edge).
    // A second start can be driven during sample extra_at (0 = none).
    task automatic run_op(input logic [1:0] o, input logic [31:0] s, input int extra_at,
                          output int busy_n, output int done_first, output int done_n,
                          output logic [31:0] res);
        busy_n = 0; done_first = 0; done_n = 0; res = 'x;
        @(negedge clk);
        start = 1'b1; op = o; src = s;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_first == 0) begin
                    done_first = i;
                    res = result;
                end
            end
            if (i == extra_at) begin
                start = 1'b1; op = 2'b00; src = 32'hFFFF_FFFF;
            end else if (i == extra_at + 1) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; src = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %0d expected 0", result); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got busy=%b done=%b expected 0/0", busy, done); end
    endtask

    task automatic test_pop_all_ones();
        int b, f, d; logic [31:0] r;
        run_op(2'b00, 32'hFFFF_FFFF, 0, b, f, d, r);
        n_checks++; if (b !== 4) begin n_fail++; $display("FAIL pop_ff_busy_cycles: got %0d expected 4", b); end
        n_checks++; if (f !== 5) begin n_fail++; $display("FAIL pop_ff_done_cycle: got %0d expected 5", f); end
        n_checks++; if (d !== 1) begin n_fail++; $display("FAIL pop_ff_done_pulses: got %0d expected 1", d); end
        n_checks++; if (r !== 32'd32) begin n_fail++; $display("FAIL pop_ff_result: got %0d expected 32", r); end
    endtask

    task automatic test_ops();
        int b, f, d; logic [31:0] r;
        run_op(2'b01, 32'h0000_000F, 0, b, f, d, r);
        n_checks++; if (r !== 32'd28) begin n_fail++; $display("FAIL zero_0f: got %0d expected 28", r); end
        run_op(2'b00, 32'h0000_0000, 0, b, f, d, r);
        n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL pop_0: got %0d expected 0", r); end
        n_checks++; if (f !== 5) begin n_fail++; $display("FAIL pop_0_done_cycle: got %0d expected 5", f); end
        run_op(2'b01, 32'h0000_0000, 0, b, f, d, r);
        n_checks++; if (r !== 32'd32) begin n_fail++; $display("FAIL zero_0: got %0d expected 32", r); end
        run_op(2'b10, 32'h8000_0001, 0, b, f, d, r);
        n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL par_80000001: got %0d expected 0", r); end
        run_op(2'b10, 32'h8000_0003, 0, b, f, d, r);
        n_checks++; if (r !== 32'd1) begin n_fail++; $display("FAIL par_80000003: got %0d expected 1", r); end
        run_op(2'b11, 32'hFFFF_FFFF, 0, b, f, d, r);
        n_checks++; if (r !== 32'd1) begin n_fail++; $display("FAIL all1_ffffffff: got %0d expected 1", r); end
        run_op(2'b11, 32'hFFFF_FF7F, 0, b, f, d, r);
        n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL all1_ffffff7f: got %0d expected 0", r); end
        run_op(2'b00, 32'hA5C3_0F01, 0, b, f, d, r);
        n_checks++; if (r !== 32'd13) begin n_fail++; $display("FAIL pop_a5c30f01: got %0d expected 13", r); end
    endtask

    task automatic test_start_in_run();
        int b, f, d; logic [31:0] r;
        run_op(2'b00, 32'h0000_00FF, 2, b, f, d, r);
        n_checks++; if (r !== 32'd8) begin n_fail++; $display("FAIL ignore_start_result: got %0d expected 8", r); end
        n_checks++; if (d !== 1) begin n_fail++; $display("FAIL ignore_start_done_pulses: got %0d expected 1", d); end
        n_checks++; if (b !== 4 || f !== 5) begin n_fail++; $display("FAIL ignore_start_timing: got busy=%0d done_at=%0d expected 4/5", b, f); end
    endtask

    task automatic test_back_to_back();
        bit found = 1'b0;
        int done_at = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b00; src = 32'h0000_0001;
        for (int i = 1; i <= 10 && !found; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done) found = 1'b1;
        end
        n_checks++; if (!found || result !== 32'd1) begin n_fail++; $display("FAIL b2b_first: got found=%b result=%0d expected 1/1", found, result); end
        start = 1'b1; op = 2'b00; src = 32'h0000_0003;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_restart: got busy=%b done=%b expected 1/0", busy, done); end
        n_checks++; if (result !== 32'd1) begin n_fail++; $display("FAIL b2b_hold: got %0d expected 1", result); end
        for (int i = 2; i <= 10 && done_at == 0; i++) begin
            @(negedge clk);
            if (done) done_at = i;
        end
        n_checks++; if (done_at !== 5) begin n_fail++; $display("FAIL b2b_second_done_cycle: got %0d expected 5", done_at); end
        n_checks++; if (result !== 32'd2) begin n_fail++; $display("FAIL b2b_second_result: got %0d expected 2", result); end
    endtask

    task automatic test_reset_mid_run();
        int dn = 0, bn = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b00; src = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL async_reset_ctrl: got busy=%b done=%b expected 0/0", busy, done); end
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL async_reset_result: got %0d expected 0", result); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dn++;
            if (busy) bn++;
        end
        n_checks++; if (dn !== 0 || bn !== 0) begin n_fail++; $display("FAIL post_reset_quiet: got done=%0d busy=%0d expected 0/0", dn, bn); end
    endtask

`ifdef BCNT_FLUSH_EN
    task automatic test_flush();
        int b, f, d, dn; logic [31:0] r;
        run_op(2'b00, 32'h0000_00FF, 0, b, f, d, r);
        n_checks++; if (r !== 32'd8) begin n_fail++; $display("FAIL flush_setup: got %0d expected 8", r); end
        @(negedge clk);
        start = 1'b1; op = 2'b00; src = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy); end
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        n_checks++; if (dn !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d expected 0", dn); end
        n_checks++; if (result !== 32'd8) begin n_fail++; $display("FAIL flush_result_held: got %0d expected 8", result); end
        start = 1'b1; flush = 1'b1; src = 32'h0000_0001;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_beats_start: got busy=%b expected 0", busy); end
        run_op(2'b00, 32'h0000_0003, 0, b, f, d, r);
        n_checks++; if (r !== 32'd2 || f !== 5) begin n_fail++; $display("FAIL flush_then_op: got result=%0d done_at=%0d expected 2/5", r, f); end
    endtask
`endif

    initial begin
        test_reset();
        test_pop_all_ones();
        test_ops();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_run();
`ifdef BCNT_FLUSH_EN
        test_flush();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
